// File: rtl/eth_parse_pkg.sv
// Shared constants, parser state encoding and DNS record layout for the
// ICMP port-unreachable DNS extractor.
package eth_parse_pkg;

  localparam logic [15:0] ETH_FTYPE_IP      = 16'h0800;
  localparam logic [7:0]  IP_PROTO_ICMP     = 8'h01;
  localparam logic [7:0]  IP_PROTO_UDP      = 8'h11;
  localparam logic [7:0]  IPV4_VIHL_NOOPT   = 8'h45;
  localparam logic [7:0]  ICMP_DEST_UNREACH = 8'd3;
  localparam logic [7:0]  ICMP_PORT_UNREACH = 8'd3;

  // 64-bit beat index carrying each header field (frame byte offset / 8)
  localparam logic [9:0] BEAT_SOF         = 10'd0;
  localparam logic [9:0] BEAT_ETH         = 10'd1;
  localparam logic [9:0] BEAT_IP_PROTO    = 10'd2;
  localparam logic [9:0] BEAT_L4          = 10'd4;
  localparam logic [9:0] BEAT_INNER_IP    = 10'd5;
  localparam logic [9:0] BEAT_INNER_PROTO = 10'd6;
  localparam logic [9:0] BEAT_ADDR        = 10'd7;
  localparam logic [9:0] BEAT_QPORT       = 10'd8;
  localparam logic [9:0] BEAT_DNS_TAIL    = 10'd9;
  localparam logic [9:0] BEAT_CNT_MAX     = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_PARSE   = 2'd1,
    ST_DISCARD = 2'd2
  } parse_state_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_udp;
    logic [15:0] dst_udp;
    logic [15:0] dns_id;
    logic [15:0] dns_flags;
    logic [15:0] dns_qdcount;
    logic [15:0] dns_ancount;
  } dns_rec_t;

  localparam int REC_W = 160;

  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dns_rec_fifo.sv
// First-word-fall-through record FIFO; full/empty derive from occupancy
// before any same-cycle pop, so a push into a full FIFO is always refused.
module dns_rec_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 16
) (
  input  logic                     clk156,
  input  logic                     eth_rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/icmp_dns_extract.sv
// Passive tap parser: extracts quoted IP/UDP/DNS headers from ICMP 3/3
// frames into a record FIFO and keeps saturating statistics.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_SYNC    | frame alignment unknown; wait for a tlast beat
//   ST_PARSE   | at frame start or mid-frame with all checks passing
//   ST_DISCARD | frame rejected; wait for its tlast
module icmp_dns_extract
  import eth_parse_pkg::*;
#(
  parameter logic [15:0] DNS_PORT   = 16'd53,
  parameter logic [15:0] HIT_PORT   = 16'd12345,
  parameter int          FIFO_DEPTH = 16,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                 clk156,
  input  logic                 eth_rst_n,
  input  logic                 cfg_port_chk,
  input  logic                 s_axis_tvalid,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 m_rec_tvalid,
  input  logic                 m_rec_tready,
  output logic [REC_W-1:0]     m_rec_tdata,
  output logic [CNT_WIDTH-1:0] stat_match,
  output logic [CNT_WIDTH-1:0] stat_drop,
  output logic [CNT_WIDTH-1:0] stat_hit,
  output logic [CNT_WIDTH-1:0] stat_err,
  output logic [7:0]           debug
);

  parse_state_t state, state_nxt;
  logic [9:0]  beat_cnt;
  logic [7:0][7:0] lane;
  logic [15:0] f_be01, f_be23, f_be45, f_be67;
  logic        port_chk_r, ihl_bad_r, cand_r, keep9_ok_r;
  logic        eth_ip_r, udp_r, hit_r;
  logic [31:0] src_ip_r, dst_ip_r;
  logic [15:0] src_udp_r, dst_udp_r, dns_id_r, flags_r, qd_r, an_r;
  logic        frame_last, mism_now, ihl_err_now, cand_now, short_now;
  logic        keep9_now, keep9_ok, tail_now;
  logic        rec_commit, err_inc, hit_inc;
  logic        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
  dns_rec_t    rec_din;

  assign lane       = s_axis_tdata;
  assign f_be01     = be16(lane[0], lane[1]);
  assign f_be23     = be16(lane[2], lane[3]);
  assign f_be45     = be16(lane[4], lane[5]);
  assign f_be67     = be16(lane[6], lane[7]);
  assign frame_last = s_axis_tvalid & s_axis_tlast;
  assign short_now  = beat_cnt < BEAT_DNS_TAIL;
  assign tail_now   = beat_cnt == BEAT_DNS_TAIL;
  assign keep9_now  = (s_axis_tkeep | 8'hC0) == 8'hFF;
  assign keep9_ok   = tail_now ? keep9_now : keep9_ok_r;
  assign cand_now   = cand_r | (beat_cnt == BEAT_IP_PROTO && lane[7] == IP_PROTO_ICMP);

  // Field checks for the beat currently on the bus
  always_comb begin
    mism_now    = 1'b0;
    ihl_err_now = 1'b0;
    case (beat_cnt)
      BEAT_ETH:         mism_now = f_be45 != ETH_FTYPE_IP;
      BEAT_IP_PROTO: begin
        mism_now    = ihl_bad_r || lane[7] != IP_PROTO_ICMP;
        ihl_err_now = ihl_bad_r && lane[7] == IP_PROTO_ICMP;
      end
      BEAT_L4:          mism_now = lane[2] != ICMP_DEST_UNREACH || lane[3] != ICMP_PORT_UNREACH;
      BEAT_INNER_IP: begin
        mism_now    = lane[2] != IPV4_VIHL_NOOPT;
        ihl_err_now = lane[2] != IPV4_VIHL_NOOPT;
      end
      BEAT_INNER_PROTO: mism_now = lane[3] != IP_PROTO_UDP;
      BEAT_QPORT:       mism_now = port_chk_r && f_be01 != DNS_PORT;
      default:          mism_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) state <= ST_SYNC;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SYNC:    if (frame_last) state_nxt = ST_PARSE;
      ST_PARSE:   if (frame_last) state_nxt = ST_PARSE;
                  else if (s_axis_tvalid && mism_now) state_nxt = ST_DISCARD;
      ST_DISCARD: if (frame_last) state_nxt = ST_PARSE;
      default:    state_nxt = ST_SYNC;
    endcase
  end

  always_comb begin
    rec_commit = (state == ST_PARSE) & frame_last & cand_now & ~mism_now & ~short_now
                 & ~s_axis_tuser & keep9_ok;
    err_inc    = (state == ST_PARSE) & s_axis_tvalid & (ihl_err_now
                 | (s_axis_tlast & cand_now & ~mism_now & (short_now | s_axis_tuser)));
    // Outer-UDP port hits are tracked independently of the ICMP checks
    hit_inc    = (state != ST_SYNC) & frame_last & ~s_axis_tuser
                 & ((beat_cnt == BEAT_L4) ? (udp_r && f_be45 == HIT_PORT) : hit_r);
  end

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      beat_cnt <= '0;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast)                 beat_cnt <= '0;
      else if (beat_cnt != BEAT_CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      {port_chk_r, ihl_bad_r, cand_r, keep9_ok_r, eth_ip_r, udp_r, hit_r} <= '0;
      {src_ip_r, dst_ip_r, src_udp_r, dst_udp_r} <= '0;
      {dns_id_r, flags_r, qd_r, an_r} <= '0;
    end else if (s_axis_tvalid) begin
      case (beat_cnt)
        BEAT_SOF:         port_chk_r <= cfg_port_chk;
        BEAT_ETH: begin
          ihl_bad_r <= lane[6] != IPV4_VIHL_NOOPT;
          eth_ip_r  <= f_be45 == ETH_FTYPE_IP;
        end
        BEAT_IP_PROTO: begin
          cand_r <= lane[7] == IP_PROTO_ICMP;
          udp_r  <= eth_ip_r && lane[7] == IP_PROTO_UDP;
        end
        BEAT_L4:          hit_r <= udp_r && f_be45 == HIT_PORT;
        BEAT_INNER_PROTO: src_ip_r[31:16] <= f_be67;
        BEAT_ADDR: begin
          src_ip_r[15:0] <= f_be01;
          dst_ip_r       <= {f_be23, f_be45};
          src_udp_r      <= f_be67;
        end
        BEAT_QPORT: begin
          dst_udp_r <= f_be01;
          dns_id_r  <= f_be67;
        end
        BEAT_DNS_TAIL: begin
          flags_r    <= f_be01;
          qd_r       <= f_be23;
          an_r       <= f_be45;
          keep9_ok_r <= keep9_now;
        end
        default: ;
      endcase
      if (s_axis_tlast)
        {ihl_bad_r, cand_r, keep9_ok_r, eth_ip_r, udp_r, hit_r} <= '0;
    end
  end

  always_comb begin
    rec_din.src_ip      = src_ip_r;
    rec_din.dst_ip      = dst_ip_r;
    rec_din.src_udp     = src_udp_r;
    rec_din.dst_udp     = dst_udp_r;
    rec_din.dns_id      = dns_id_r;
    rec_din.dns_flags   = tail_now ? f_be01 : flags_r;
    rec_din.dns_qdcount = tail_now ? f_be23 : qd_r;
    rec_din.dns_ancount = tail_now ? f_be45 : an_r;
  end

  dns_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk156    (clk156),
    .eth_rst_n (eth_rst_n),
    .push      (rec_commit),
    .din       (rec_din),
    .pop       (m_rec_tready),
    .dout      (m_rec_tdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  assign m_rec_tvalid = ~fifo_empty;
  assign debug        = stat_match[7:0];

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      stat_match <= '0;
      stat_drop  <= '0;
      stat_hit   <= '0;
      stat_err   <= '0;
    end else begin
      if (rec_commit && !fifo_full && !(&stat_match)) stat_match <= stat_match + 1'b1;
      if (rec_commit &&  fifo_full && !(&stat_drop))  stat_drop  <= stat_drop + 1'b1;
      if (hit_inc && !(&stat_hit))                    stat_hit   <= stat_hit + 1'b1;
      if (err_inc && !(&stat_err))                    stat_err   <= stat_err + 1'b1;
    end
  end

endmodule

// File: tb/tb_icmp_dns_extract.sv
// Directed bench for icmp_dns_extract: sync frame, extraction, port check,
// FIFO full/drop, error counting, port hits and mid-frame reset.
module tb_icmp_dns_extract;

  localparam int CW = 32;
  localparam logic [159:0] REC53 = {32'h0a000001, 32'hc0a80164, 16'h9c40, 16'h0035,
                                    16'hbeef, 16'h0100, 16'h0001, 16'h0000};
  localparam logic [159:0] REC54 = {32'h0a000001, 32'hc0a80164, 16'h9c40, 16'h0036,
                                    16'hbeef, 16'h0100, 16'h0001, 16'h0000};

  logic          clk156 = 1'b0;
  logic          eth_rst_n;
  logic          cfg_port_chk;
  logic          s_axis_tvalid;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic          m_rec_tvalid;
  logic          m_rec_tready;
  logic [159:0]  m_rec_tdata;
  logic [CW-1:0] stat_match, stat_drop, stat_hit, stat_err;
  logic [7:0]    debug;

  logic [7:0] fb [0:79];
  int n_cmp;
  int n_bad;

  always #5 clk156 = ~clk156;

  icmp_dns_extract #(
    .DNS_PORT   (16'd53),
    .HIT_PORT   (16'd12345),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk156        (clk156),
    .eth_rst_n     (eth_rst_n),
    .cfg_port_chk  (cfg_port_chk),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_rec_tvalid  (m_rec_tvalid),
    .m_rec_tready  (m_rec_tready),
    .m_rec_tdata   (m_rec_tdata),
    .stat_match    (stat_match),
    .stat_drop     (stat_drop),
    .stat_hit      (stat_hit),
    .stat_err      (stat_err),
    .debug         (debug)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 80; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = 8'h10 + 8'(i);
      fb[6 + i] = 8'h20 + 8'(i);
    end
    fb[12] = 8'h08; fb[13] = 8'h00;
  endtask

  task automatic build_icmp(input logic [7:0] vihl, input logic [15:0] qport);
    clear_frame();
    fb[14] = vihl;  fb[17] = 8'h42; fb[22] = 8'h40; fb[23] = 8'h01;
    fb[26] = 8'hc0; fb[27] = 8'ha8; fb[28] = 8'h01; fb[29] = 8'h64;
    fb[30] = 8'h0a; fb[31] = 8'h00; fb[32] = 8'h00; fb[33] = 8'h01;
    fb[34] = 8'h03; fb[35] = 8'h03;
    fb[42] = 8'h45; fb[45] = 8'h26; fb[50] = 8'h40; fb[51] = 8'h11;
    fb[54] = 8'h0a; fb[55] = 8'h00; fb[56] = 8'h00; fb[57] = 8'h01;
    fb[58] = 8'hc0; fb[59] = 8'ha8; fb[60] = 8'h01; fb[61] = 8'h64;
    fb[62] = 8'h9c; fb[63] = 8'h40;
    fb[64] = qport[15:8]; fb[65] = qport[7:0];
    fb[67] = 8'h12;
    fb[70] = 8'hbe; fb[71] = 8'hef;
    fb[72] = 8'h01; fb[73] = 8'h00;
    fb[74] = 8'h00; fb[75] = 8'h01;
  endtask

  task automatic build_udp(input logic [15:0] dport);
    clear_frame();
    fb[14] = 8'h45; fb[23] = 8'h11;
    fb[34] = 8'h12; fb[35] = 8'h34;
    fb[36] = dport[15:8]; fb[37] = dport[7:0];
  endtask

  // Drives fb[0..nbytes-1]; optionally pulses tready on the tlast beat and
  // drops eth_rst_n for the single beat numbered rst_beat.
  task automatic send(input int nbytes, input bit err, input bit pop_last, input int rst_beat);
    int nbeats;
    nbeats = (nbytes + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk156);
      s_axis_tvalid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        s_axis_tdata[k*8 +: 8] = (b*8 + k < nbytes) ? fb[b*8 + k] : 8'h00;
        s_axis_tkeep[k]        = (b*8 + k < nbytes);
      end
      s_axis_tlast = (b == nbeats - 1);
      s_axis_tuser = (b == nbeats - 1) && err;
      eth_rst_n    = (b != rst_beat);
      if (pop_last && b == nbeats - 1) m_rec_tready = 1'b1;
    end
    @(negedge clk156);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    eth_rst_n     = 1'b1;
    if (pop_last) m_rec_tready = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [159:0] exp);
    check({tag, "_valid"}, m_rec_tvalid, 1'b1);
    check({tag, "_data"}, m_rec_tdata, exp);
    @(negedge clk156);
    m_rec_tready = 1'b1;
    @(negedge clk156);
    m_rec_tready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    eth_rst_n     = 1'b0;
    cfg_port_chk  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_rec_tready  = 1'b0;
    repeat (3) @(negedge clk156);
    check("rst_tvalid", m_rec_tvalid, 1'b0);
    check("rst_tdata", m_rec_tdata, '0);
    check("rst_match", stat_match, '0);
    check("rst_drop", stat_drop, '0);
    check("rst_hit", stat_hit, '0);
    check("rst_err", stat_err, '0);
    check("rst_debug", debug, '0);
    eth_rst_n = 1'b1;

    // first frame after reset only establishes alignment
    build_icmp(8'h45, 16'd53);
    send(80, 0, 0, -1);
    check("sync_no_rec", m_rec_tvalid, 1'b0);
    check("sync_match", stat_match, 32'd0);

    send(80, 0, 0, -1);
    check("rec1_match", stat_match, 32'd1);
    check("rec1_debug", debug, 8'd1);
    pop_check("rec1", REC53);
    check("rec1_empty", m_rec_tvalid, 1'b0);

    cfg_port_chk = 1'b1;
    build_icmp(8'h45, 16'd54);
    send(80, 0, 0, -1);
    check("pchk_no_rec", m_rec_tvalid, 1'b0);
    check("pchk_match", stat_match, 32'd1);
    check("pchk_err", stat_err, 32'd0);
    cfg_port_chk = 1'b0;
    send(80, 0, 0, -1);
    check("nochk_match", stat_match, 32'd2);
    pop_check("nochk", REC54);

    // fill the 4-entry FIFO with tready low, two more commits are dropped
    build_icmp(8'h45, 16'd53);
    for (int i = 0; i < 6; i++) send(80, 0, 0, -1);
    check("full_match", stat_match, 32'd6);
    check("full_drop", stat_drop, 32'd2);
    check("full_head", m_rec_tdata, REC53);
    send(80, 0, 1, -1);
    check("fullpop_drop", stat_drop, 32'd3);
    check("fullpop_match", stat_match, 32'd6);
    pop_check("drain0", REC53);
    pop_check("drain1", REC53);
    pop_check("drain2", REC53);
    check("drain_empty", m_rec_tvalid, 1'b0);

    build_icmp(8'h46, 16'd53);
    send(80, 0, 0, -1);
    check("ihl_err", stat_err, 32'd1);
    check("ihl_no_rec", m_rec_tvalid, 1'b0);
    build_icmp(8'h45, 16'd53);
    send(64, 0, 0, -1);
    check("short_err", stat_err, 32'd2);
    check("short_no_rec", m_rec_tvalid, 1'b0);
    send(80, 1, 0, -1);
    check("tuser_err", stat_err, 32'd3);
    check("tuser_no_rec", m_rec_tvalid, 1'b0);
    check("err_match", stat_match, 32'd6);

    build_udp(16'd1000);
    send(64, 0, 0, -1);
    check("udp_other_hit", stat_hit, 32'd0);
    build_udp(16'd12345);
    send(64, 0, 0, -1);
    send(64, 0, 0, -1);
    check("udp_hit", stat_hit, 32'd2);
    check("udp_err", stat_err, 32'd3);

    // two records queued, then reset lands on beat 5 of a matching frame
    build_icmp(8'h45, 16'd53);
    send(80, 0, 0, -1);
    send(80, 0, 0, -1);
    check("preq_valid", m_rec_tvalid, 1'b1);
    check("preq_match", stat_match, 32'd8);
    send(80, 0, 0, 5);
    check("mrst_valid", m_rec_tvalid, 1'b0);
    check("mrst_tdata", m_rec_tdata, '0);
    check("mrst_match", stat_match, 32'd0);
    check("mrst_drop", stat_drop, 32'd0);
    check("mrst_hit", stat_hit, 32'd0);
    check("mrst_err", stat_err, 32'd0);
    send(80, 0, 0, -1);
    check("post_match", stat_match, 32'd1);
    pop_check("post", REC53);
    check("post_empty", m_rec_tvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
